// File: rtl/serial_adder_8b_pkg.sv
// Shared ALU definitions: default operand width, FSM state encodings and
// a counter-width helper used by the serial adder.
package serial_adder_8b_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Guards the degenerate WIDTH=1 case, where $clog2 would yield zero bits.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_8b_full_adder_1b.sv
// 1-bit full adder composed of two half-adder cells with their carries ORed.
module half_adder_1b (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  import serial_adder_8b_pkg::*;

  logic s0, c0, c1;

  half_adder_1b u_ha0 (.x(a),  .y(b),  .s(s0), .c(c0));
  half_adder_1b u_ha1 (.x(s0), .y(ci), .s(s),  .c(c1));

  assign co = c0 | c1;
endmodule

// File: rtl/serial_adder_8b.sv
// Bit-serial adder: one full adder processes operands LSB-first over WIDTH
// cycles; results are captured on entry to DONE and held until the next one.
module serial_adder_8b
  import serial_adder_8b_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             zero,
  output logic             overflow
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg, sum_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             carry_reg, cout_reg, ovf_reg;
  logic             fa_s, fa_co;
  logic             last_bit;

  full_adder_1b u_fa (
    .a  (a_reg[0]),
    .b  (b_reg[0]),
    .ci (carry_reg),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (cnt_reg == LAST_BIT);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      sum_reg   <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            cnt_reg   <= '0;
            res_reg   <= '0;
          end
        end
        RUN: begin
          a_reg     <= a_reg >> 1;
          b_reg     <= b_reg >> 1;
          carry_reg <= fa_co;
          res_reg   <= {fa_s, res_reg[WIDTH-1:1]};
          cnt_reg   <= cnt_reg + 1'b1;
          if (last_bit) begin
            sum_reg  <= {fa_s, res_reg[WIDTH-1:1]};
            cout_reg <= fa_co;
            // carry_reg here is still the carry produced by bit WIDTH-2
            ovf_reg  <= carry_reg ^ fa_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_reg == RUN);
  assign done     = (state_reg == DONE);
  assign sum      = sum_reg;
  assign cout     = cout_reg;
  assign zero     = (sum_reg == '0);
  assign overflow = ovf_reg;

endmodule
